// File: rtl/fp_align_stage_if.sv
// Handshake and operand bundle for the floating-point alignment stage.
// The master drives operands and Out_Ready; the slave (the stage) drives results.
interface fp_align_stage_if #(
   parameter int unsigned ExponentSize = 8,
   parameter int unsigned FractionSize = 23
);
   localparam int unsigned MantissaSize = FractionSize + 1;
   localparam int unsigned RoundingSize = MantissaSize + 3;

   logic                    In_Valid;
   logic                    In_Ready;
   logic [ExponentSize-1:0] Exponent1;
   logic [ExponentSize-1:0] Exponent2;
   logic [MantissaSize-1:0] Mantissa1;
   logic [MantissaSize-1:0] Mantissa2;
   logic                    EffOperation;
   logic                    Out_Valid;
   logic                    Out_Ready;
   logic [RoundingSize-1:0] Adder1;
   logic [RoundingSize-1:0] Adder2;
   logic                    CarryIn;
   logic [ExponentSize-1:0] ExponentBase;
   logic                    Swapped;

   modport master (
      output In_Valid, Exponent1, Exponent2, Mantissa1, Mantissa2, EffOperation, Out_Ready,
      input  In_Ready, Out_Valid, Adder1, Adder2, CarryIn, ExponentBase, Swapped
   );

   modport slave (
      input  In_Valid, Exponent1, Exponent2, Mantissa1, Mantissa2, EffOperation, Out_Ready,
      output In_Ready, Out_Valid, Adder1, Adder2, CarryIn, ExponentBase, Swapped
   );
endinterface

// File: rtl/fp_align_stage.sv
// Operand ordering, exponent difference and sticky right-shift for FP add/sub,
// registered behind a 2-entry skid buffer so both handshake directions are registered.
module fp_align_stage #(
   parameter int unsigned ExponentSize = 8,
   parameter int unsigned FractionSize = 23
) (
   input  logic            Clk,
   input  logic            Rst_n,
   fp_align_stage_if.slave bus
);
   localparam int unsigned MantissaSize = FractionSize + 1;
   localparam int unsigned RoundingSize = MantissaSize + 3;

   typedef struct packed {
      logic [RoundingSize-1:0] adder1;
      logic [RoundingSize-1:0] adder2;
      logic                    carry_in;
      logic [ExponentSize-1:0] exp_base;
      logic                    swapped;
   } result_t;

   logic                    w_swap;
   logic                    w_far;
   logic [ExponentSize-1:0] w_diff;
   logic [ExponentSize-1:0] w_exp_large;
   logic [MantissaSize-1:0] w_man_small;
   logic [MantissaSize-1:0] w_man_large;
   logic [RoundingSize-1:0] w_ext;
   logic [RoundingSize-1:0] w_shifted;
   logic [RoundingSize-1:0] w_lost_mask;
   logic [RoundingSize-1:0] w_aligned;
   result_t                 w_calc;
   logic                    w_in_fire;
   logic                    w_main_load;

   result_t r_main;
   result_t r_skid;
   logic    r_main_valid;
   logic    r_skid_valid;

   always_comb begin
      w_swap = (bus.Exponent2 > bus.Exponent1) ||
               ((bus.Exponent2 == bus.Exponent1) && (bus.Mantissa2 > bus.Mantissa1));
      w_diff      = w_swap ? (bus.Exponent2 - bus.Exponent1) : (bus.Exponent1 - bus.Exponent2);
      w_exp_large = w_swap ? bus.Exponent2 : bus.Exponent1;
      w_man_large = w_swap ? bus.Mantissa2 : bus.Mantissa1;
      w_man_small = w_swap ? bus.Mantissa1 : bus.Mantissa2;

      // Beyond RoundingSize every bit is shifted out; only the sticky survives.
      w_far       = (32'(w_diff) >= RoundingSize);
      w_ext       = {w_man_small, 3'b000};
      w_shifted   = w_ext >> w_diff;
      w_lost_mask = ~({RoundingSize{1'b1}} << w_diff);
      if (w_far)
         w_aligned = {{(RoundingSize-1){1'b0}}, |w_man_small};
      else
         w_aligned = {w_shifted[RoundingSize-1:1], w_shifted[0] | (|(w_ext & w_lost_mask))};

      w_calc.adder1   = bus.EffOperation ? ~w_aligned : w_aligned;
      w_calc.adder2   = {w_man_large, 3'b000};
      w_calc.carry_in = bus.EffOperation;
      w_calc.exp_base = w_exp_large;
      w_calc.swapped  = w_swap;
   end

   assign w_in_fire   = bus.In_Valid & ~r_skid_valid;
   assign w_main_load = ~r_main_valid | bus.Out_Ready;

   // In_Ready is low whenever skid is full, so skid and input never compete for main.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_main       <= '0;
         r_skid       <= '0;
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (w_main_load) begin
         if (r_skid_valid) begin
            r_main       <= r_skid;
            r_main_valid <= 1'b1;
            r_skid_valid <= 1'b0;
         end else begin
            r_main_valid <= w_in_fire;
            if (w_in_fire)
               r_main <= w_calc;
         end
      end else if (w_in_fire) begin
         r_skid       <= w_calc;
         r_skid_valid <= 1'b1;
      end
   end

   assign bus.In_Ready     = ~r_skid_valid;
   assign bus.Out_Valid    = r_main_valid;
   assign bus.Adder1       = r_main.adder1;
   assign bus.Adder2       = r_main.adder2;
   assign bus.CarryIn      = r_main.carry_in;
   assign bus.ExponentBase = r_main.exp_base;
   assign bus.Swapped      = r_main.swapped;
endmodule

// File: tb/tb_fp_align_stage.sv
// Directed bench for fp_align_stage: single-precision vectors, backpressure,
// mid-stream reset, and a double-precision far-shift case.
module tb_fp_align_stage;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   fp_align_stage_if #(.ExponentSize(8),  .FractionSize(23)) if1 ();
   fp_align_stage_if #(.ExponentSize(11), .FractionSize(52)) if2 ();

   fp_align_stage #(.ExponentSize(8), .FractionSize(23)) u_dut (
      .Clk   (clk),
      .Rst_n (rst_n),
      .bus   (if1)
   );

   fp_align_stage #(.ExponentSize(11), .FractionSize(52)) u_dut_dp (
      .Clk   (clk),
      .Rst_n (rst_n),
      .bus   (if2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_sp(input string tag,
                          input logic [7:0] e1, input logic [23:0] m1,
                          input logic [7:0] e2, input logic [23:0] m2, input logic op,
                          input logic [26:0] a1, input logic [26:0] a2, input logic cin,
                          input logic [7:0] eb, input logic sw);
      if1.Exponent1    = e1;
      if1.Mantissa1    = m1;
      if1.Exponent2    = e2;
      if1.Mantissa2    = m2;
      if1.EffOperation = op;
      if1.In_Valid     = 1'b1;
      if1.Out_Ready    = 1'b1;
      @(posedge clk); #1;
      if1.In_Valid = 1'b0;
      check({tag, "_valid"}, 64'(if1.Out_Valid), 64'd1);
      check({tag, "_adder1"}, 64'(if1.Adder1), 64'(a1));
      check({tag, "_adder2"}, 64'(if1.Adder2), 64'(a2));
      check({tag, "_cin"}, 64'(if1.CarryIn), 64'(cin));
      check({tag, "_expbase"}, 64'(if1.ExponentBase), 64'(eb));
      check({tag, "_swapped"}, 64'(if1.Swapped), 64'(sw));
   endtask

   logic [63:0] exp_a2 [4];
   int          sent;
   int          got;
   logic        in_f;
   logic        out_f;

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      if1.In_Valid = 1'b0; if1.Out_Ready = 1'b0; if1.EffOperation = 1'b0;
      if1.Exponent1 = '0; if1.Exponent2 = '0; if1.Mantissa1 = '0; if1.Mantissa2 = '0;
      if2.In_Valid = 1'b0; if2.Out_Ready = 1'b0; if2.EffOperation = 1'b0;
      if2.Exponent1 = '0; if2.Exponent2 = '0; if2.Mantissa1 = '0; if2.Mantissa2 = '0;

      #2;
      check("rst_out_valid", 64'(if1.Out_Valid), 64'd0);
      check("rst_in_ready", 64'(if1.In_Ready), 64'd1);
      check("rst_adder1", 64'(if1.Adder1), 64'd0);
      check("rst_adder2", 64'(if1.Adder2), 64'd0);
      check("rst_expbase", 64'(if1.ExponentBase), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      send_sp("add", 8'h82, 24'hC00000, 8'h80, 24'h800000, 1'b0,
              27'h1000000, 27'h6000000, 1'b0, 8'h82, 1'b0);
      send_sp("sub", 8'h82, 24'hC00000, 8'h80, 24'h800000, 1'b1,
              27'h6FFFFFF, 27'h6000000, 1'b1, 8'h82, 1'b0);
      send_sp("sticky", 8'h80, 24'h800001, 8'h84, 24'h800000, 1'b0,
              27'h0400001, 27'h4000000, 1'b0, 8'h84, 1'b1);
      send_sp("far40", 8'hA8, 24'h800000, 8'h80, 24'h800000, 1'b0,
              27'h0000001, 27'h4000000, 1'b0, 8'hA8, 1'b0);
      send_sp("eqexp", 8'h90, 24'h900000, 8'h90, 24'hA00000, 1'b0,
              27'h4800000, 27'h5000000, 1'b0, 8'h90, 1'b1);
      send_sp("eqmag", 8'h85, 24'hB00000, 8'h85, 24'hB00000, 1'b1,
              27'h27FFFFF, 27'h5800000, 1'b1, 8'h85, 1'b0);
      send_sp("d25", 8'h99, 24'h800000, 8'h80, 24'h800000, 1'b0,
              27'h0000002, 27'h4000000, 1'b0, 8'h99, 1'b0);
      send_sp("d27", 8'h9B, 24'h800000, 8'h80, 24'h800000, 1'b0,
              27'h0000001, 27'h4000000, 1'b0, 8'h9B, 1'b0);
      @(posedge clk); #1;
      check("drain_empty", 64'(if1.Out_Valid), 64'd0);

      // Backpressure: A..D streamed while the output is stalled for 4 cycles
      exp_a2[0] = 64'h4000000;
      exp_a2[1] = 64'h4080000;
      exp_a2[2] = 64'h4100000;
      exp_a2[3] = 64'h4180000;
      sent = 0;
      got  = 0;
      if1.Exponent1 = 8'h81;
      if1.Exponent2 = 8'h80;
      if1.Mantissa2 = 24'h800000;
      if1.EffOperation = 1'b0;
      for (int c = 0; c < 16 && got < 4; c++) begin
         if1.Out_Ready = (c >= 4);
         if1.In_Valid  = (sent < 4);
         if1.Mantissa1 = 24'h800000 + 24'(sent) * 24'h010000;
         if (c == 1) check("bp_skid_accept", 64'(if1.In_Ready), 64'd1);
         if (c == 2 || c == 3) begin
            check("bp_in_ready_low", 64'(if1.In_Ready), 64'd0);
            check("bp_hold_valid", 64'(if1.Out_Valid), 64'd1);
            check("bp_hold_data", 64'(if1.Adder2), exp_a2[0]);
         end
         if (c >= 4 && c <= 7) check("bp_no_gap", 64'(if1.Out_Valid), 64'd1);
         in_f  = if1.In_Valid & if1.In_Ready;
         out_f = if1.Out_Valid & if1.Out_Ready;
         if (out_f) begin
            check("bp_order", 64'(if1.Adder2), exp_a2[got]);
            got++;
         end
         @(posedge clk); #1;
         if (in_f) sent++;
      end
      if1.In_Valid = 1'b0;
      check("bp_count", 64'(got), 64'd4);
      check("bp_empty_after", 64'(if1.Out_Valid), 64'd0);

      // Reset with main and skid both holding data
      if1.Out_Ready = 1'b0;
      if1.In_Valid  = 1'b1;
      if1.Mantissa1 = 24'h880000;
      @(posedge clk); #1;
      if1.Mantissa1 = 24'h890000;
      @(posedge clk); #1;
      if1.In_Valid = 1'b0;
      check("rst2_full", 64'(if1.In_Ready), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst2_out_valid", 64'(if1.Out_Valid), 64'd0);
      check("rst2_in_ready", 64'(if1.In_Ready), 64'd1);
      check("rst2_adder2", 64'(if1.Adder2), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      if1.Out_Ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("rst2_no_stale", 64'(if1.Out_Valid), 64'd0);
      end

      // Double precision: d = 2000 and d = 2
      if2.Exponent1 = 11'd2010;
      if2.Exponent2 = 11'd10;
      if2.Mantissa1 = 53'h10000000000000;
      if2.Mantissa2 = 53'h10000000000000;
      if2.In_Valid  = 1'b1;
      if2.Out_Ready = 1'b1;
      @(posedge clk); #1;
      check("dp_far_valid", 64'(if2.Out_Valid), 64'd1);
      check("dp_far_adder1", 64'(if2.Adder1), 64'd1);
      check("dp_far_adder2", 64'(if2.Adder2), 64'h80000000000000);
      check("dp_far_expbase", 64'(if2.ExponentBase), 64'd2010);
      check("dp_far_swapped", 64'(if2.Swapped), 64'd0);
      if2.Exponent1 = 11'd12;
      @(posedge clk); #1;
      if2.In_Valid = 1'b0;
      check("dp_d2_adder1", 64'(if2.Adder1), 64'h20000000000000);
      check("dp_d2_expbase", 64'(if2.ExponentBase), 64'd12);
      @(posedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
